// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink and indicator blocks: state encodings,
// parameter legality limits and a counter-width helper.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int MIN_CLK_DIV   = 1;
  localparam int MIN_ON_TICKS  = 1;
  localparam int MIN_OFF_TICKS = 1;
  localparam int MIN_CNT_W     = 1;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks, with a
// synchronous restart that holds the count at zero.
module tick_gen
  import blink_pkg::*;
#(
  parameter int CLK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_clk_div
    $error("tick_gen: CLK_DIV must be >= 1");
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pulse_blinker.sv
// Turns single-cycle event strobes into visible LED blinks, one per event,
// queueing events that arrive mid-blink in a saturating pending counter.
module pulse_blinker
  import blink_pkg::*;
#(
  parameter int CLK_DIV   = 100_000,
  parameter int ON_TICKS  = 250,
  parameter int OFF_TICKS = 250,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ovf_clr,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PW        = cnt_width(MAX_TICKS);
  localparam logic [PW-1:0]    ON_LAST  = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0]    OFF_LAST = PW'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  if (ON_TICKS < MIN_ON_TICKS) begin : g_bad_on_ticks
    $error("pulse_blinker: ON_TICKS must be >= 1");
  end
  if (OFF_TICKS < MIN_OFF_TICKS) begin : g_bad_off_ticks
    $error("pulse_blinker: OFF_TICKS must be >= 1");
  end
  if (CNT_W < MIN_CNT_W) begin : g_bad_cnt_w
    $error("pulse_blinker: CNT_W must be >= 1");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;

  logic tick;
  logic start_cond;
  logic start;
  logic inc;
  logic dec;
  logic at_max;
  logic ovf_set;

  // Prescaler sits at zero while idle so the first tick lands CLK_DIV
  // cycles into the blink; afterwards it free-runs across ON/OFF.
  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == ST_IDLE),
    .tick    (tick)
  );

  assign start_cond = pulse_in | (pending_q != '0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start_cond) begin
          state_d = ST_ON;
          start   = 1'b1;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (phase_q == ON_LAST) begin
            state_d = ST_OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            if (start_cond) begin
              state_d = ST_ON;
              start   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // A start prefers the live strobe over the queue, so a strobe that
  // coincides with a start leaves the queue untouched.
  always_comb begin
    inc        = pulse_in & ~start;
    dec        = start & ~pulse_in;
    at_max     = (pending_q == PEND_MAX);
    ovf_set    = inc & at_max;
    pending_d  = pending_q;
    if (inc && !at_max) begin
      pending_d = pending_q + 1'b1;
    end else if (dec) begin
      pending_d = pending_q - 1'b1;
    end
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    led_d      = (state_d == ST_ON);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with CLK_DIV=4, ON_TICKS=2, OFF_TICKS=3
// (ON = 8 cycles, OFF = 12 cycles) and a 2-bit pending queue.
module tb_pulse_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_in = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  pulse_blinker #(
    .CLK_DIV   (4),
    .ON_TICKS  (2),
    .OFF_TICKS (3),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .ovf_clr  (ovf_clr),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Cycle c is the interval following clock edge c; edge 1 is the first
  // edge after reset release. Inputs driven in cycle c are sampled at c+1.
  task automatic do_reset();
    rst      = 1'b1;
    pulse_in = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({led, busy, pending, overflow} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %b exp 00000", {led, busy, pending, overflow});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if ({led, busy, pending, overflow} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle c=%0d got %b exp 00000", c, {led, busy, pending, overflow});
      end
    end
  endtask

  task automatic test_single();
    logic exp_led, exp_busy;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      exp_led  = (c >= 11 && c <= 18);
      exp_busy = (c >= 11 && c <= 30);
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL single_led c=%0d got %b exp %b", c, led, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL single_busy c=%0d got %b exp %b", c, busy, exp_busy);
      end
      vectors++;
      if (pending !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL single_pending c=%0d got %0d exp 0", c, pending);
      end
      pulse_in = (c == 10);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       exp_led, exp_busy;
    logic [1:0] exp_pend;
    do_reset();
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      exp_led  = (c >= 11 && c <= 18) || (c >= 31 && c <= 38) || (c >= 51 && c <= 58);
      exp_busy = (c >= 11 && c <= 70);
      exp_pend = (c < 12) ? 2'd0 : (c < 13) ? 2'd1 : (c < 31) ? 2'd2 : (c < 51) ? 2'd1 : 2'd0;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL b2b_led c=%0d got %b exp %b", c, led, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL b2b_busy c=%0d got %b exp %b", c, busy, exp_busy);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("[TB] FAIL b2b_pending c=%0d got %0d exp %0d", c, pending, exp_pend);
      end
      pulse_in = (c >= 10 && c <= 12);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_saturation();
    logic       exp_led, exp_ovf, led_prev;
    logic [1:0] exp_pend;
    int         blinks;
    do_reset();
    blinks   = 0;
    led_prev = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (led === 1'b1 && led_prev === 1'b0) blinks++;
      led_prev = led;
      exp_led  = (c >= 11 && c <= 18) || (c >= 31 && c <= 38) ||
                 (c >= 51 && c <= 58) || (c >= 71 && c <= 78);
      exp_ovf  = (c >= 16 && c <= 100);
      exp_pend = (c < 13) ? 2'd0 : (c == 13) ? 2'd1 : (c == 14) ? 2'd2 :
                 (c < 31) ? 2'd3 : (c < 51) ? 2'd2 : (c < 71) ? 2'd1 : 2'd0;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL sat_led c=%0d got %b exp %b", c, led, exp_led);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("[TB] FAIL sat_pending c=%0d got %0d exp %0d", c, pending, exp_pend);
      end
      vectors++;
      if (overflow !== exp_ovf) begin
        miscompares++;
        $display("[TB] FAIL sat_overflow c=%0d got %b exp %b", c, overflow, exp_ovf);
      end
      pulse_in = (c == 10) || (c >= 12 && c <= 17);
      ovf_clr  = (c == 100);
    end
    pulse_in = 1'b0;
    ovf_clr  = 1'b0;
    vectors++;
    if (blinks !== 4) begin
      miscompares++;
      $display("[TB] FAIL sat_blink_count got %0d exp 4", blinks);
    end
  endtask

  task automatic test_transition_pulse();
    logic       exp_led, exp_busy, led_prev;
    logic [1:0] exp_pend;
    int         blinks;
    do_reset();
    blinks   = 0;
    led_prev = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (led === 1'b1 && led_prev === 1'b0) blinks++;
      led_prev = led;
      exp_led  = (c >= 11 && c <= 18) || (c >= 31 && c <= 38) ||
                 (c >= 51 && c <= 58) || (c >= 71 && c <= 78);
      exp_busy = (c >= 11 && c <= 90);
      exp_pend = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c < 51) ? 2'd2 : (c < 71) ? 2'd1 : 2'd0;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL trans_led c=%0d got %b exp %b", c, led, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL trans_busy c=%0d got %b exp %b", c, busy, exp_busy);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("[TB] FAIL trans_pending c=%0d got %0d exp %0d", c, pending, exp_pend);
      end
      pulse_in = (c >= 10 && c <= 12) || (c == 30);
    end
    pulse_in = 1'b0;
    vectors++;
    if (blinks !== 4) begin
      miscompares++;
      $display("[TB] FAIL trans_blink_count got %0d exp 4", blinks);
    end
  endtask

  task automatic test_reset_mid_blink();
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      pulse_in = (c >= 10 && c <= 12);
    end
    vectors++;
    if ({led, busy, pending} !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre got %b exp 1110", {led, busy, pending});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({led, busy, pending, overflow} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async got %b exp 00000", {led, busy, pending, overflow});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      vectors++;
      if ({led, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL midrst_quiet c=%0d got led/busy %b exp 00", c, {led, busy});
      end
    end
  endtask

  task automatic test_ovf_set_clr_same_cycle();
    logic       exp_ovf;
    logic [1:0] exp_pend;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      exp_ovf  = (c == 15);
      exp_pend = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : 2'd3;
      vectors++;
      if (overflow !== exp_ovf) begin
        miscompares++;
        $display("[TB] FAIL setclr_overflow c=%0d got %b exp %b", c, overflow, exp_ovf);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("[TB] FAIL setclr_pending c=%0d got %0d exp %0d", c, pending, exp_pend);
      end
      pulse_in = (c >= 10 && c <= 14);
      ovf_clr  = (c == 14) || (c == 15);
    end
    pulse_in = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_transition_pulse();
    test_reset_mid_blink();
    test_ovf_set_clr_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_blinker.md
Name: pulse_blinker

Overview:
- Output-side companion to the button input path: takes single-cycle event pulses from internal logic and makes them human-visible as timed LED blinks, one blink per event.
- Queues events that arrive while a blink is in progress in a saturating pending counter.
- Single clock domain with an internal tick enable; no derived clocks.

Parameters:
- CLK_DIV, 100_000: clk cycles per tick; must be >= 1.
- ON_TICKS, 250: ticks the LED is lit per blink; must be >= 1.
- OFF_TICKS, 250: ticks the LED is dark after each blink (inter-blink gap); must be >= 1.
- CNT_W, 4: width of the pending-event counter; max queue depth is 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high.
- pulse_in  input  1  event strobe, one clk wide, synchronous to clk.
- ovf_clr  input  1  clears the sticky overflow flag.
- led  output  1  blink output, registered.
- busy  output  1  high while the FSM is not IDLE, registered.
- pending  output  CNT_W  events queued but not yet started, registered.
- overflow  output  1  sticky flag set when an event is dropped at saturation, registered.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - led, busy, pending and overflow are 0.
  - Prescaler and phase counters are 0.
- States: IDLE, ON, OFF. led=1 only in ON; busy=1 in ON and OFF.
- start condition: pulse_in=1 or pending!=0.
- IDLE:
  - If the start condition holds, go to ON on the next edge.
  - Prescaler and phase counter restart at 0.
  - Latency: pulse_in at edge n with pending=0 gives led=1 after edge n+1.
- ON:
  - Lasts exactly ON_TICKS*CLK_DIV clk cycles.
  - Then go to OFF with phase=0.
- OFF:
  - Lasts exactly OFF_TICKS*CLK_DIV cycles.
  - At the end, if the start condition holds, go directly to ON. Otherwise go to IDLE.
- Prescaler:
  - Counts 0..CLK_DIV-1 and emits a one-cycle tick at CLK_DIV-1.
  - Free-runs across the ON/OFF boundaries, so timing is exact.
  - Restarts only on the IDLE->ON transition.
- Starting a blink consumes one event: pulse_in in that cycle if present, otherwise pending is decremented.
- Pending update per cycle:
  - +1 if pulse_in is not consumed by a start.
  - -1 if a start consumes from pending.
  - Net zero if both happen in the same cycle.
- Saturation:
  - An increment at pending=2^CNT_W-1 with no simultaneous decrement leaves pending unchanged and sets overflow=1.
  - At max with a simultaneous decrement, pending stays at max and overflow is not set.
- overflow:
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- rst mid-blink aborts immediately: led drops asynchronously and the queue is discarded.
- pulse_in during ON or OFF never alters the current blink timing.

Decomposition:
- Shared package blink_pkg holds:
  - state encodings (IDLE=2'd0, ON=2'd1, OFF=2'd2);
  - parameter-legality check constants.
- One sub-module, tick_gen:
  - CLK_DIV prescaler with a synchronous restart input and a tick output.
  - Reused by other LED and indicator blocks.
- FSM, phase counter and pending counter live in pulse_blinker.

Test Plan:
- Bench parameters: CLK_DIV=4, ON_TICKS=2, OFF_TICKS=3. This gives ON = 8 cycles and OFF = 12 cycles.
- Scenario 1, single pulse_in at edge 10:
  - led=1 on cycles 11-18, led=0 on cycles 19-30.
  - busy=0 from cycle 31.
  - pending=0 throughout.
- Scenario 2, pulse_in at edges 10, 11 and 12:
  - pending goes 1 then 2.
  - led high on cycles 11-18, 31-38 and 51-58.
  - pending drops to 1 at 31 and to 0 at 51.
  - busy=0 from cycle 71.
- Scenario 3, CNT_W=2 with 6 pulses during the first ON:
  - pending saturates at 3 and overflow=1.
  - Exactly 4 blinks occur in total.
  - ovf_clr pulse gives overflow=0 the next cycle.
- Scenario 4, pulse_in exactly on the OFF->ON transition cycle with pending=2:
  - pending stays 2 on that edge.
  - Total blinks equal total pulses.
- Scenario 5, rst asserted mid-ON with pending=2:
  - led, busy, pending and overflow are 0 immediately, without waiting for a clock edge.
  - After release with no pulse_in, led stays 0 for 100 cycles.
- Scenario 6, saturating pulse_in and ovf_clr in the same cycle:
  - overflow=1 afterwards.
  - ovf_clr alone on the next cycle gives overflow=0.
